display_scan_ctrl: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver. It latches N_DIGITS 4-bit codes plus per-digit decimal-point, blank and blink attributes into shadow registers, then scans them one digit at a time onto a shared segment bus with one-hot anode enables. It adds a ghosting guard interval, frame-based blinking and selectable output polarity. It sits between the system datapath (result/error codes) and the board display pins, and supersedes the per-digit static decoder.

---
 rtl/display_pkg.sv | 37 +++
 rtl/display_scan_ctrl_if.sv | 35 +++
 rtl/display_scan_ctrl_glyph.sv | 40 ++++
 rtl/display_scan_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared types and glyph/code constants for the seven-segment
//               scan controller. Segment bit order: bit0=A .. bit6=G, bit7=DP.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

   typedef logic [7:0] seg_t;

   // Glyphs in logical polarity (1 = segment lit), DP always clear here.
   localparam seg_t SEG_0     = 8'h3F;  // ABCDEF
   localparam seg_t SEG_1     = 8'h06;  // BC
   localparam seg_t SEG_2     = 8'h5B;  // ABDEG
   localparam seg_t SEG_3     = 8'h4F;  // ABCDG
   localparam seg_t SEG_4     = 8'h66;  // BCFG
   localparam seg_t SEG_5     = 8'h6D;  // ACDFG
   localparam seg_t SEG_6     = 8'h7D;  // ACDEFG
   localparam seg_t SEG_7     = 8'h07;  // ABC
   localparam seg_t SEG_8     = 8'h7F;  // ABCDEFG
   localparam seg_t SEG_9     = 8'h6F;  // ABCDFG
   localparam seg_t SEG_A     = 8'h77;  // A: ABCEFG
   localparam seg_t SEG_B     = 8'h7C;  // b: CDEFG
   localparam seg_t SEG_C     = 8'h39;  // C: ADEF
   localparam seg_t SEG_D     = 8'h5C;  // o: CDEG
   localparam seg_t SEG_E     = 8'h50;  // r: EG
   localparam seg_t SEG_F     = 8'h79;  // E: ADEFG
   localparam seg_t SEG_BLANK = 8'h00;

   // Codes used by the datapath to spell "Err" / "o" style messages.
   localparam logic [3:0] CODE_O = 4'hD;
   localparam logic [3:0] CODE_R = 4'hE;
   localparam logic [3:0] CODE_E = 4'hF;

endpackage
`default_nettype wire

// File: rtl/display_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl_if
// Description : Attribute load bundle and display pin bundle for the scan
//               controller. The master side owns the attributes, the slave
//               side (the controller) drives the display pins.
// Revision    : 1.0 - initial release
// ============================================================================
interface display_scan_ctrl_if
   import display_pkg::*;
#(
   parameter int N_DIGITS = 8
) ();

   logic                     load;
   logic [N_DIGITS-1:0][3:0] digits;
   logic [N_DIGITS-1:0]      dp_en;
   logic [N_DIGITS-1:0]      blank;
   logic [N_DIGITS-1:0]      blink_en;
   seg_t                     segments;
   logic [N_DIGITS-1:0]      anodes;
   logic                     frame_tick;

   modport master (
      output load, digits, dp_en, blank, blink_en,
      input  segments, anodes, frame_tick
   );

   modport slave (
      input  load, digits, dp_en, blank, blink_en,
      output segments, anodes, frame_tick
   );

endinterface
`default_nettype wire

// File: rtl/display_scan_ctrl_glyph.sv
`default_nettype none
// ============================================================================
// Module      : seg7_glyph
// Description : Combinational 4-bit code to seven-segment glyph decoder,
//               logical polarity, DP bit always clear.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_glyph
   import display_pkg::*;
(
   input  logic [3:0] code_i,
   output seg_t       seg_o
);

   // Table lookup of the glyph for the selected code.
   always_comb begin
      seg_o = SEG_BLANK;
      case (code_i)
         4'h0:    seg_o = SEG_0;
         4'h1:    seg_o = SEG_1;
         4'h2:    seg_o = SEG_2;
         4'h3:    seg_o = SEG_3;
         4'h4:    seg_o = SEG_4;
         4'h5:    seg_o = SEG_5;
         4'h6:    seg_o = SEG_6;
         4'h7:    seg_o = SEG_7;
         4'h8:    seg_o = SEG_8;
         4'h9:    seg_o = SEG_9;
         4'hA:    seg_o = SEG_A;
         4'hB:    seg_o = SEG_B;
         4'hC:    seg_o = SEG_C;
         CODE_O:  seg_o = SEG_D;
         CODE_R:  seg_o = SEG_E;
         CODE_E:  seg_o = SEG_F;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl
// Description : Time-multiplexed seven-segment driver. Shadow-registers the
//               digit attributes, scans one digit per REFRESH_DIV cycles with
//               a leading all-anodes-off guard window, blinks selected digits
//               every BLINK_FRAMES frames, and registers all outputs at the
//               chosen physical polarity.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int N_DIGITS     = 8,
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD        = 500,
   parameter int BLINK_FRAMES = 32,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   display_scan_ctrl_if.slave  bus_if
);

   localparam int PRESC_W = (REFRESH_DIV > 1)  ? $clog2(REFRESH_DIV)  : 1;
   localparam int IDX_W   = (N_DIGITS > 1)     ? $clog2(N_DIGITS)     : 1;
   localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
   localparam logic [FRAME_W-1:0]  FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
   localparam logic [N_DIGITS-1:0] AN_ONE     = N_DIGITS'(1);

   // XOR masks that turn logical levels into physical pin levels; they are
   // also the physical "everything off" value used at reset.
   localparam seg_t                SEG_MASK = {8{ACTIVE_LOW}};
   localparam logic [N_DIGITS-1:0] AN_MASK  = {N_DIGITS{ACTIVE_LOW}};

   // ------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------------
   if (N_DIGITS < 1 || N_DIGITS > 16) begin : g_chk_ndigits
      $error("display_scan_ctrl: N_DIGITS must be in 1..16");
   end
   if (REFRESH_DIV <= GUARD || GUARD < 0) begin : g_chk_guard
      $error("display_scan_ctrl: REFRESH_DIV must exceed GUARD (GUARD >= 0)");
   end
   if (BLINK_FRAMES < 1) begin : g_chk_blink
      $error("display_scan_ctrl: BLINK_FRAMES must be at least 1");
   end

   // ------------------------------------------------------------------------
   // Shadow registers
   // ------------------------------------------------------------------------
   logic [N_DIGITS-1:0][3:0] digits_q;
   logic [N_DIGITS-1:0]      dp_q;
   logic [N_DIGITS-1:0]      blank_q;
   logic [N_DIGITS-1:0]      blink_q;

   // Capture the whole attribute bundle on the load strobe; reset blanks all.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         digits_q <= '0;
         dp_q     <= '0;
         blank_q  <= '1;
         blink_q  <= '0;
      end else if (bus_if.load) begin
         digits_q <= bus_if.digits;
         dp_q     <= bus_if.dp_en;
         blank_q  <= bus_if.blank;
         blink_q  <= bus_if.blink_en;
      end
   end

   // ------------------------------------------------------------------------
   // Slot prescaler
   // ------------------------------------------------------------------------
   logic [PRESC_W-1:0] presc_q;
   logic [PRESC_W-1:0] presc_d;
   logic               presc_last_w;

   assign presc_last_w = (presc_q == PRESC_LAST);
   assign presc_d      = presc_last_w ? '0 : presc_q + 1'b1;

   // Free-running slot timer, one wrap per digit slot.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   // ------------------------------------------------------------------------
   // Scan index; a single-digit display keeps it pinned at 0
   // ------------------------------------------------------------------------
   logic [IDX_W-1:0] idx_w;
   logic             wrap_w;

   if (N_DIGITS > 1) begin : g_idx_multi
      localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
      logic [IDX_W-1:0] idx_q;
      logic [IDX_W-1:0] idx_d;

      assign wrap_w = presc_last_w && (idx_q == IDX_LAST);
      assign idx_d  = wrap_w ? '0 : (presc_last_w ? idx_q + 1'b1 : idx_q);
      assign idx_w  = idx_q;

      // Advance to the next digit at the end of every slot.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            idx_q <= '0;
         end else begin
            idx_q <= idx_d;
         end
      end
   end else begin : g_idx_single
      assign wrap_w = presc_last_w;
      assign idx_w  = '0;
   end

   // ------------------------------------------------------------------------
   // Frame counter and blink phase
   // ------------------------------------------------------------------------
   logic [FRAME_W-1:0] frame_q;
   logic [FRAME_W-1:0] frame_d;
   logic               blink_phase_q;
   logic               blink_phase_d;

   // Count completed frames and flip the blink phase every BLINK_FRAMES.
   always_comb begin
      frame_d       = frame_q;
      blink_phase_d = blink_phase_q;
      if (wrap_w) begin
         if (frame_q == FRAME_LAST) begin
            frame_d       = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            frame_d = frame_q + 1'b1;
         end
      end
   end

   // Frame/blink state; phase starts visible.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         frame_q       <= '0;
         blink_phase_q <= 1'b1;
      end else begin
         frame_q       <= frame_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   // ------------------------------------------------------------------------
   // Digit select, decode and blanking (logical polarity)
   // ------------------------------------------------------------------------
   logic [3:0]          sel_code_w;
   seg_t                glyph_w;
   logic                dark_w;
   logic                guard_done_w;
   seg_t                seg_log_w;
   logic [N_DIGITS-1:0] an_log_w;

   assign sel_code_w = digits_q[idx_w];

   seg7_glyph u_glyph (
      .code_i (sel_code_w),
      .seg_o  (glyph_w)
   );

   if (GUARD > 0) begin : g_guard_on
      assign guard_done_w = (presc_q >= PRESC_W'(GUARD));
   end else begin : g_guard_off
      assign guard_done_w = 1'b1;
   end

   assign dark_w    = blank_q[idx_w] | (blink_q[idx_w] & ~blink_phase_q);
   assign seg_log_w = dark_w ? SEG_BLANK : (glyph_w | {dp_q[idx_w], 7'b0});
   assign an_log_w  = guard_done_w ? (AN_ONE << idx_w) : '0;

   // ------------------------------------------------------------------------
   // Output registers, physical polarity applied here
   // ------------------------------------------------------------------------
   seg_t                seg_q;
   logic [N_DIGITS-1:0] an_q;
   logic                tick_q;

   // Register pins so no input reaches an output without a flop in between.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         seg_q  <= SEG_MASK;
         an_q   <= AN_MASK;
         tick_q <= 1'b0;
      end else begin
         seg_q  <= seg_log_w ^ SEG_MASK;
         an_q   <= an_log_w ^ AN_MASK;
         tick_q <= wrap_w;
      end
   end

   assign bus_if.segments   = seg_q;
   assign bus_if.anodes     = an_q;
   assign bus_if.frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_ctrl
// Description : Scoreboard bench. Two controllers (active-high and
//               active-low) share one stimulus stream; a cycle-count model
//               predicts every output cycle and a monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;
   import display_pkg::*;

   localparam int N  = 4;
   localparam int R  = 8;
   localparam int G  = 2;
   localparam int BF = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Shared stimulus
   logic                ld = 1'b0;
   logic [N-1:0][3:0]   dg = '0;
   logic [N-1:0]        dp = '0;
   logic [N-1:0]        bl = '0;
   logic [N-1:0]        bk = '0;

   display_scan_ctrl_if #(.N_DIGITS(N)) bus_hi ();
   display_scan_ctrl_if #(.N_DIGITS(N)) bus_lo ();

   assign bus_hi.load = ld;  assign bus_hi.digits = dg;  assign bus_hi.dp_en = dp;
   assign bus_hi.blank = bl; assign bus_hi.blink_en = bk;
   assign bus_lo.load = ld;  assign bus_lo.digits = dg;  assign bus_lo.dp_en = dp;
   assign bus_lo.blank = bl; assign bus_lo.blink_en = bk;

   display_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(R), .GUARD(G),
                       .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b0)) dut_hi (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_if (bus_hi)
   );

   display_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(R), .GUARD(G),
                       .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b1)) dut_lo (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_if (bus_lo)
   );

   int total = 0;
   int bad   = 0;

   task automatic check_out(input string tag,
                            input seg_t gs, input logic [N-1:0] ga, input logic gf,
                            input seg_t ws, input logic [N-1:0] wa, input logic wf);
      total++;
      if (gs !== ws || ga !== wa || gf !== wf) begin
         bad++;
         $display("FAIL %s t=%0t: got seg=%02h an=%b tick=%b, want seg=%02h an=%b tick=%b",
                  tag, $time, gs, ga, gf, ws, wa, wf);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: everything derived from edges counted since reset
   // ------------------------------------------------------------------------
   typedef struct packed {
      seg_t         seg;
      logic [N-1:0] an;
      logic         ft;
   } exp_t;

   exp_t        expq[$];
   int unsigned cyc;
   logic [7:0]  glyph_tab [16];
   logic [3:0]  m_dg [N];
   bit          m_dp [N];
   bit          m_bl [N];
   bit          m_bk [N];

   initial begin
      glyph_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5C, 8'h50, 8'h79};
   end

   always @(posedge clk) begin
      int unsigned c, slot, pos, frames;
      bit          phase, dark;
      exp_t        e;
      if (!rst_n) begin
         cyc = 0;
         for (int i = 0; i < N; i++) begin
            m_dg[i] = 4'h0; m_dp[i] = 1'b0; m_bl[i] = 1'b1; m_bk[i] = 1'b0;
         end
      end else begin
         cyc++;
         // Output after edge cyc shows the scan position of the cycle before.
         c      = cyc - 1;
         pos    = c % R;
         slot   = (c / R) % N;
         frames = c / (R * N);
         phase  = ((frames / BF) % 2) == 0;
         dark   = m_bl[slot] || (m_bk[slot] && !phase);
         e.seg  = dark ? 8'h00 : (glyph_tab[m_dg[slot]] | (m_dp[slot] ? 8'h80 : 8'h00));
         e.an   = (pos >= G) ? (N'(1) << slot) : '0;
         e.ft   = (cyc % (R * N)) == 0;
         expq.push_back(e);
         if (ld) begin
            for (int i = 0; i < N; i++) begin
               m_dg[i] = dg[i]; m_dp[i] = dp[i]; m_bl[i] = bl[i]; m_bk[i] = bk[i];
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Monitor: one expected entry per output cycle
   // ------------------------------------------------------------------------
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         expq.delete();
         check_out("reset_hi", bus_hi.segments, bus_hi.anodes, bus_hi.frame_tick,
                   8'h00, '0, 1'b0);
         check_out("reset_lo", bus_lo.segments, bus_lo.anodes, bus_lo.frame_tick,
                   8'hFF, '1, 1'b0);
      end else if (expq.size() != 0) begin
         e = expq.pop_front();
         check_out("scan_hi", bus_hi.segments, bus_hi.anodes, bus_hi.frame_tick,
                   e.seg, e.an, e.ft);
         check_out("scan_lo", bus_lo.segments, bus_lo.anodes, bus_lo.frame_tick,
                   ~e.seg, ~e.an, e.ft);
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   task automatic do_load(input logic [N-1:0][3:0] d, input logic [N-1:0] p,
                          input logic [N-1:0] b, input logic [N-1:0] k);
      @(negedge clk); #1;
      dg = d; dp = p; bl = b; bk = k; ld = 1'b1;
      @(negedge clk); #1;
      ld = 1'b0;
      // Scramble the inputs while load is low; the shadow must ignore them.
      dg = 16'($urandom); dp = 4'($urandom); bl = 4'($urandom); bk = 4'($urandom);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      bit found;
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      dg = 16'($urandom); dp = 4'($urandom); bl = 4'($urandom); bk = 4'($urandom);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      // Dark after reset, frame ticks every N*R cycles.
      wait_cycles(100);

      // Digits 3..0, DP on digit 0.
      do_load({4'd3, 4'd2, 4'd1, 4'd0}, 4'b0001, 4'b0000, 4'b0000);
      wait_cycles(64);

      // Letter codes E / D / F on digits 3 / 1 / 2.
      do_load({4'hE, 4'hF, 4'hD, 4'h0}, 4'b0001, 4'b0000, 4'b0000);
      wait_cycles(40);

      // Blink digit 2 across several blink phases.
      do_load({4'd3, 4'd2, 4'd1, 4'd0}, 4'b0001, 4'b0000, 4'b0100);
      wait_cycles(200);

      // Random loads at random spacing, including slot-boundary collisions.
      for (int i = 0; i < 20; i++) begin
         do_load(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
         wait_cycles($urandom_range(0, 40));
      end

      // Asynchronous reset in the middle of slot 2.
      do_load({4'd8, 4'd8, 4'd8, 4'd8}, 4'b1111, 4'b0000, 4'b0000);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (cyc > 0 && ((cyc - 1) / R) % N == 2 && (cyc - 1) % R == 4) found = 1'b1;
      end
      if (!found) begin
         total++;
         bad++;
         $display("FAIL slot2_wait: got no slot 2 within bound, want slot 2 reached");
      end
      #2 rst_n = 1'b0;
      #1;
      check_out("async_reset_hi", bus_hi.segments, bus_hi.anodes, bus_hi.frame_tick,
                8'h00, '0, 1'b0);
      check_out("async_reset_lo", bus_lo.segments, bus_lo.anodes, bus_lo.frame_tick,
                8'hFF, '1, 1'b0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      // Dark until the next load, scan restarts from index 0.
      wait_cycles(100);
      do_load(16'($urandom), 4'($urandom), 4'b0000, 4'b0000);
      wait_cycles(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
